// File: rtl/maxi_burst_master.sv
// AXI3 burst master: accepts one read/write burst command at a time, drives the
// address phase, gates write beats through, and passes R/B responses back out.
module maxi_burst_master #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        cmd_ena,
  output logic        cmd_rdy,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [11:0] cmd_id,
  input  logic [3:0]  cmd_len,

  input  logic        wdata_ena,
  input  logic [31:0] wdata_data,
  output logic        wdata_rdy,

  output logic        ar_ena,
  output logic [31:0] ar_addr,
  output logic [11:0] ar_id,
  output logic [3:0]  ar_len,
  input  logic        ar_rdy,

  output logic        aw_ena,
  output logic [31:0] aw_addr,
  output logic [11:0] aw_id,
  output logic [3:0]  aw_len,
  input  logic        aw_rdy,

  output logic        w_ena,
  output logic [31:0] w_data,
  output logic [11:0] w_id,
  output logic        w_last,
  input  logic        w_rdy,

  input  logic        r_ena,
  input  logic [31:0] r_data,
  input  logic [11:0] r_id,
  input  logic        r_last,
  input  logic [1:0]  r_resp,
  output logic        r_rdy,

  input  logic        b_ena,
  input  logic [11:0] b_id,
  input  logic [1:0]  b_resp,
  output logic        b_rdy,

  output logic        rdata_ena,
  output logic [31:0] rdata_data,
  output logic [11:0] rdata_id,
  output logic        rdata_last,
  output logic        rdata_err,
  input  logic        rdata_rdy,

  output logic        wdone_ena,
  output logic [11:0] wdone_id,
  output logic        wdone_err,
  input  logic        wdone_rdy,

  output logic        proto_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RADDR = 2'd1,
    WADDR = 2'd2,
    WDATA = 2'd3
  } state_t;

  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  state_t      state;
  logic [31:0] cur_addr;
  logic [11:0] cur_id;
  logic [3:0]  cur_len;
  logic [3:0]  beat;
  logic [3:0]  rd_out;
  logic [3:0]  wr_out;

  logic        cmd_fire;
  logic        w_fire;
  logic        r_fire;
  logic        b_fire;

  // A decrement with the counter already at zero is an underflow and is dropped.
  function automatic logic [3:0] next_count(input logic [3:0] count,
                                            input logic       inc,
                                            input logic       dec);
    logic       dec_ok;
    logic [3:0] result;
    dec_ok = dec && (count != 4'd0);
    if (inc && !dec_ok) begin
      result = count + 4'd1;
    end else if (!inc && dec_ok) begin
      result = count - 4'd1;
    end else begin
      result = count;
    end
    return result;
  endfunction

  assign cmd_rdy  = (state == IDLE) && (rd_out < MAX_OUT) && (wr_out < MAX_OUT);
  assign cmd_fire = cmd_ena && cmd_rdy;

  assign ar_addr = cur_addr;
  assign ar_id   = cur_id;
  assign ar_len  = cur_len;
  assign aw_addr = cur_addr;
  assign aw_id   = cur_id;
  assign aw_len  = cur_len;

  assign w_ena     = (state == WDATA) && wdata_ena;
  assign wdata_rdy = (state == WDATA) && w_rdy;
  assign w_data    = wdata_data;
  assign w_id      = cur_id;
  assign w_last    = (beat == cur_len);
  assign w_fire    = w_ena && w_rdy;

  assign rdata_ena  = r_ena;
  assign r_rdy      = rdata_rdy;
  assign rdata_data = r_data;
  assign rdata_id   = r_id;
  assign rdata_last = r_last;
  assign rdata_err  = (r_resp != 2'd0);
  assign r_fire     = r_ena && rdata_rdy;

  assign wdone_ena = b_ena;
  assign b_rdy     = wdone_rdy;
  assign wdone_id  = b_id;
  assign wdone_err = (b_resp != 2'd0);
  assign b_fire    = b_ena && wdone_rdy;

  // Command sequencing: address phase then, for writes, the data beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ar_ena   <= 1'b0;
      aw_ena   <= 1'b0;
      cur_addr <= 32'd0;
      cur_id   <= 12'd0;
      cur_len  <= 4'd0;
      beat     <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            cur_addr <= cmd_addr;
            cur_id   <= cmd_id;
            cur_len  <= cmd_len;
            if (cmd_write) begin
              aw_ena <= 1'b1;
              state  <= WADDR;
            end else begin
              ar_ena <= 1'b1;
              state  <= RADDR;
            end
          end
        end
        RADDR: begin
          if (ar_rdy) begin
            ar_ena <= 1'b0;
            state  <= IDLE;
          end
        end
        WADDR: begin
          if (aw_rdy) begin
            aw_ena <= 1'b0;
            beat   <= 4'd0;
            state  <= WDATA;
          end
        end
        WDATA: begin
          if (w_fire) begin
            beat <= beat + 4'd1;
            if (w_last) begin
              state <= IDLE;
            end
          end
        end
        default: begin
          ar_ena <= 1'b0;
          aw_ena <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Outstanding-burst bookkeeping and sticky underflow detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_out    <= 4'd0;
      wr_out    <= 4'd0;
      proto_err <= 1'b0;
    end else begin
      rd_out <= next_count(rd_out, ar_ena && ar_rdy, r_fire && r_last);
      wr_out <= next_count(wr_out, aw_ena && aw_rdy, b_fire);
      if ((r_fire && (rd_out == 4'd0)) || (b_fire && (wr_out == 4'd0))) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_maxi_burst_master.sv
// Self-checking bench for maxi_burst_master: pass-through vector table, directed
// corner sequences, and a randomized run against a transaction-level model.
module tb_maxi_burst_master;

  localparam int MAX = 4;

  logic        clk;
  logic        rst;
  logic        cmd_ena, cmd_rdy, cmd_write;
  logic [31:0] cmd_addr;
  logic [11:0] cmd_id;
  logic [3:0]  cmd_len;
  logic        wdata_ena, wdata_rdy;
  logic [31:0] wdata_data;
  logic        ar_ena, ar_rdy;
  logic [31:0] ar_addr;
  logic [11:0] ar_id;
  logic [3:0]  ar_len;
  logic        aw_ena, aw_rdy;
  logic [31:0] aw_addr;
  logic [11:0] aw_id;
  logic [3:0]  aw_len;
  logic        w_ena, w_last, w_rdy;
  logic [31:0] w_data;
  logic [11:0] w_id;
  logic        r_ena, r_last, r_rdy;
  logic [31:0] r_data;
  logic [11:0] r_id;
  logic [1:0]  r_resp;
  logic        b_ena, b_rdy;
  logic [11:0] b_id;
  logic [1:0]  b_resp;
  logic        rdata_ena, rdata_last, rdata_err, rdata_rdy;
  logic [31:0] rdata_data;
  logic [11:0] rdata_id;
  logic        wdone_ena, wdone_err, wdone_rdy;
  logic [11:0] wdone_id;
  logic        proto_err;

  maxi_burst_master #(.MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .rst(rst),
    .cmd_ena(cmd_ena), .cmd_rdy(cmd_rdy), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_id(cmd_id), .cmd_len(cmd_len),
    .wdata_ena(wdata_ena), .wdata_data(wdata_data), .wdata_rdy(wdata_rdy),
    .ar_ena(ar_ena), .ar_addr(ar_addr), .ar_id(ar_id), .ar_len(ar_len), .ar_rdy(ar_rdy),
    .aw_ena(aw_ena), .aw_addr(aw_addr), .aw_id(aw_id), .aw_len(aw_len), .aw_rdy(aw_rdy),
    .w_ena(w_ena), .w_data(w_data), .w_id(w_id), .w_last(w_last), .w_rdy(w_rdy),
    .r_ena(r_ena), .r_data(r_data), .r_id(r_id), .r_last(r_last), .r_resp(r_resp), .r_rdy(r_rdy),
    .b_ena(b_ena), .b_id(b_id), .b_resp(b_resp), .b_rdy(b_rdy),
    .rdata_ena(rdata_ena), .rdata_data(rdata_data), .rdata_id(rdata_id),
    .rdata_last(rdata_last), .rdata_err(rdata_err), .rdata_rdy(rdata_rdy),
    .wdone_ena(wdone_ena), .wdone_id(wdone_id), .wdone_err(wdone_err), .wdone_rdy(wdone_rdy),
    .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level model: a pending address phase, remaining write beats,
  // and the number of bursts in flight per direction.
  bit          m_pend, m_pw, m_err;
  logic [31:0] m_addr;
  logic [11:0] m_id;
  logic [3:0]  m_len;
  int          m_wleft, m_rd, m_wr;
  bit          f_cmd, f_ar, f_aw, f_w, f_w_last, f_r, f_b;
  logic [11:0] f_id;
  logic [3:0]  f_len;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 1'b0; m_pw = 1'b0; m_err = 1'b0;
    m_addr = 32'd0; m_id = 12'd0; m_len = 4'd0;
    m_wleft = 0; m_rd = 0; m_wr = 0;
  endtask

  task automatic settle();
    bit exp_rdy, exp_ar, exp_aw, exp_w;
    #1;
    exp_rdy = !m_pend && (m_wleft == 0) && (m_rd < MAX) && (m_wr < MAX);
    exp_ar  = m_pend && !m_pw;
    exp_aw  = m_pend && m_pw;
    exp_w   = (m_wleft > 0) && wdata_ena;
    chk("cmd_rdy", cmd_rdy, exp_rdy);
    chk("ar_ena", ar_ena, exp_ar);
    chk("aw_ena", aw_ena, exp_aw);
    if (exp_ar) begin
      chk("ar_addr", ar_addr, m_addr);
      chk("ar_id", ar_id, m_id);
      chk("ar_len", ar_len, m_len);
    end
    if (exp_aw) begin
      chk("aw_addr", aw_addr, m_addr);
      chk("aw_id", aw_id, m_id);
      chk("aw_len", aw_len, m_len);
    end
    chk("w_ena", w_ena, exp_w);
    chk("wdata_rdy", wdata_rdy, (m_wleft > 0) && w_rdy);
    if (exp_w) begin
      chk("w_data", w_data, wdata_data);
      chk("w_id", w_id, m_id);
      chk("w_last", w_last, m_wleft == 1);
    end
    chk("rdata_ena", rdata_ena, r_ena);
    chk("r_rdy", r_rdy, rdata_rdy);
    chk("rdata_data", rdata_data, r_data);
    chk("rdata_id", rdata_id, r_id);
    chk("rdata_last", rdata_last, r_last);
    chk("rdata_err", rdata_err, r_resp != 2'd0);
    chk("wdone_ena", wdone_ena, b_ena);
    chk("b_rdy", b_rdy, wdone_rdy);
    chk("wdone_id", wdone_id, b_id);
    chk("wdone_err", wdone_err, b_resp != 2'd0);
    chk("proto_err", proto_err, m_err);
    f_cmd    = cmd_ena && exp_rdy;
    f_ar     = exp_ar && ar_rdy;
    f_aw     = exp_aw && aw_rdy;
    f_w      = exp_w && w_rdy;
    f_w_last = f_w && (m_wleft == 1);
    f_r      = r_ena && rdata_rdy;
    f_b      = b_ena && wdone_rdy;
    f_id     = m_id;
    f_len    = m_len;
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (f_r && m_rd == 0) m_err = 1'b1;
      if (f_b && m_wr == 0) m_err = 1'b1;
      m_rd = m_rd + (f_ar ? 1 : 0) - ((f_r && r_last && m_rd > 0) ? 1 : 0);
      m_wr = m_wr + (f_aw ? 1 : 0) - ((f_b && m_wr > 0) ? 1 : 0);
      if (f_cmd) begin
        m_pend = 1'b1; m_pw = cmd_write;
        m_addr = cmd_addr; m_id = cmd_id; m_len = cmd_len;
      end
      if (f_ar) m_pend = 1'b0;
      if (f_aw) begin
        m_pend  = 1'b0;
        m_wleft = int'(m_len) + 1;
      end
      if (f_w) m_wleft--;
    end
    @(negedge clk);
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  typedef struct {
    logic        r_ena;
    logic [31:0] r_data;
    logic [11:0] r_id;
    logic        r_last;
    logic [1:0]  r_resp;
    logic        rdata_rdy;
    logic        b_ena;
    logic [11:0] b_id;
    logic [1:0]  b_resp;
    logic        wdone_rdy;
    logic        x_rdata_ena;
    logic        x_rdata_err;
    logic        x_r_rdy;
    logic        x_wdone_ena;
    logic        x_wdone_err;
    logic        x_b_rdy;
  } vec_t;

  vec_t vecs[6];

  int          rq_id[$];
  int          rq_len[$];
  int          bq[$];
  int          rbeat;
  int          nbeats;
  logic [4:0]  pat;

  initial begin
    vecs[0] = '{1'b1, 32'hdeadbeef, 12'h005, 1'b1, 2'd0, 1'b1, 1'b0, 12'h000, 2'd0, 1'b0,
                1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'h12345678, 12'habc, 1'b0, 2'd2, 1'b0, 1'b1, 12'h123, 2'd1, 1'b1,
                1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 32'h00000000, 12'h000, 1'b0, 2'd3, 1'b1, 1'b1, 12'hfff, 2'd3, 1'b0,
                1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 32'hffffffff, 12'hfff, 1'b1, 2'd1, 1'b1, 1'b0, 12'h001, 2'd2, 1'b1,
                1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 32'h00000000, 12'h000, 1'b0, 2'd0, 1'b0, 1'b0, 12'h000, 2'd0, 1'b0,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'ha5a55a5a, 12'h800, 1'b0, 2'd0, 1'b1, 1'b1, 12'h7ff, 2'd0, 1'b1,
                1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    rst = 1'b1;
    cmd_ena = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0; cmd_id = 12'd0; cmd_len = 4'd0;
    wdata_ena = 1'b0; wdata_data = 32'd0;
    ar_rdy = 1'b0; aw_rdy = 1'b0; w_rdy = 1'b0;
    r_ena = 1'b0; r_data = 32'd0; r_id = 12'd0; r_last = 1'b0; r_resp = 2'd0;
    b_ena = 1'b0; b_id = 12'd0; b_resp = 2'd0;
    rdata_rdy = 1'b0; wdone_rdy = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    settle();
    chk("reset_cmd_rdy", cmd_rdy, 1'b1);
    chk("reset_proto_err", proto_err, 1'b0);
    chk("reset_ar_ena", ar_ena, 1'b0);
    chk("reset_aw_ena", aw_ena, 1'b0);
    advance();

    // Pass-through vectors for the R and B response paths
    for (int i = 0; i < 6; i++) begin
      r_ena = vecs[i].r_ena; r_data = vecs[i].r_data; r_id = vecs[i].r_id;
      r_last = vecs[i].r_last; r_resp = vecs[i].r_resp; rdata_rdy = vecs[i].rdata_rdy;
      b_ena = vecs[i].b_ena; b_id = vecs[i].b_id; b_resp = vecs[i].b_resp;
      wdone_rdy = vecs[i].wdone_rdy;
      settle();
      chk("tbl_rdata_ena", rdata_ena, vecs[i].x_rdata_ena);
      chk("tbl_rdata_err", rdata_err, vecs[i].x_rdata_err);
      chk("tbl_r_rdy", r_rdy, vecs[i].x_r_rdy);
      chk("tbl_rdata_data", rdata_data, vecs[i].r_data);
      chk("tbl_rdata_id", rdata_id, vecs[i].r_id);
      chk("tbl_rdata_last", rdata_last, vecs[i].r_last);
      chk("tbl_wdone_ena", wdone_ena, vecs[i].x_wdone_ena);
      chk("tbl_wdone_err", wdone_err, vecs[i].x_wdone_err);
      chk("tbl_b_rdy", b_rdy, vecs[i].x_b_rdy);
      chk("tbl_wdone_id", wdone_id, vecs[i].b_id);
      advance();
    end
    r_ena = 1'b0; b_ena = 1'b0; r_last = 1'b0; r_resp = 2'd0; b_resp = 2'd0;
    settle();
    chk("tbl_proto_err", proto_err, 1'b1);
    advance();
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Single read burst
    cmd_ena = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40; cmd_id = 12'd5; cmd_len = 4'd3;
    ar_rdy = 1'b1;
    settle();
    chk("rd_cmd_rdy", cmd_rdy, 1'b1);
    advance();
    cmd_ena = 1'b0;
    settle();
    chk("rd_ar_ena", ar_ena, 1'b1);
    chk("rd_ar_len", ar_len, 4'd3);
    chk("rd_ar_addr", ar_addr, 32'h40);
    advance();
    settle();
    chk("rd_ar_done", ar_ena, 1'b0);
    advance();
    rdata_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r_ena = 1'b1; r_id = 12'd5; r_data = 32'h1000 + 32'(i); r_last = (i == 3); r_resp = 2'd0;
      settle();
      chk("rd_beat_last", rdata_last, i == 3);
      chk("rd_beat_id", rdata_id, 12'd5);
      advance();
    end
    r_ena = 1'b0; r_last = 1'b0;
    settle();
    chk("rd_no_proto_err", proto_err, 1'b0);
    advance();

    // Write burst with W backpressure
    cmd_ena = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h100; cmd_id = 12'd7; cmd_len = 4'd2;
    aw_rdy = 1'b1;
    tick();
    cmd_ena = 1'b0;
    wdata_ena = 1'b1; wdata_data = 32'ha0; w_rdy = 1'b1;
    settle();
    chk("wr_aw_ena", aw_ena, 1'b1);
    chk("wr_aw_before_w", w_ena, 1'b0);
    advance();
    nbeats = 0;
    pat = 5'b10101;
    for (int k = 0; k < 5; k++) begin
      w_rdy = pat[k];
      wdata_data = 32'ha0 + 32'(nbeats);
      settle();
      if (w_ena && w_rdy) begin
        chk("wr_data", w_data, 32'ha0 + 32'(nbeats));
        chk("wr_last", w_last, nbeats == 2);
        nbeats++;
      end
      advance();
    end
    wdata_ena = 1'b0;
    chk("wr_beats", nbeats, 3);
    b_ena = 1'b1; b_id = 12'd7; b_resp = 2'd2; wdone_rdy = 1'b1;
    settle();
    chk("wr_done_err", wdone_err, 1'b1);
    chk("wr_done_id", wdone_id, 12'd7);
    advance();
    b_ena = 1'b0; b_resp = 2'd0;

    // Outstanding limit: four reads with R held idle
    ar_rdy = 1'b1;
    for (int j = 0; j < 4; j++) begin
      cmd_ena = 1'b1; cmd_write = 1'b0; cmd_id = 12'(j); cmd_len = 4'd0;
      tick();
      cmd_ena = 1'b0;
      tick();
    end
    settle();
    chk("lim_full", cmd_rdy, 1'b0);
    advance();
    r_ena = 1'b1; r_last = 1'b1; r_id = 12'd0;
    settle();
    chk("lim_same_cycle", cmd_rdy, 1'b0);
    advance();
    r_ena = 1'b0;
    settle();
    chk("lim_freed", cmd_rdy, 1'b1);
    advance();
    r_ena = 1'b1;
    tick();
    r_ena = 1'b0;

    // AR accept coinciding with an R-last accept at two in flight
    ar_rdy = 1'b0;
    cmd_ena = 1'b1;
    tick();
    cmd_ena = 1'b0;
    settle();
    chk("sim_ar_held", ar_ena, 1'b1);
    advance();
    ar_rdy = 1'b1; r_ena = 1'b1; r_last = 1'b1;
    tick();
    r_ena = 1'b0;
    cmd_ena = 1'b1;
    settle();
    chk("sim_rd1", cmd_rdy, 1'b1);
    advance();
    cmd_ena = 1'b0;
    tick();
    cmd_ena = 1'b1;
    settle();
    chk("sim_one_more", cmd_rdy, 1'b1);
    advance();
    cmd_ena = 1'b0;
    tick();
    settle();
    chk("sim_full", cmd_rdy, 1'b0);
    advance();
    r_ena = 1'b1;
    repeat (4) tick();
    r_ena = 1'b0; r_last = 1'b0;

    // B response with no write in flight
    settle();
    chk("perr_before", proto_err, 1'b0);
    advance();
    b_ena = 1'b1; b_resp = 2'd0; wdone_rdy = 1'b1;
    tick();
    b_ena = 1'b0;
    for (int j = 0; j < 3; j++) begin
      settle();
      chk("perr_sticky", proto_err, 1'b1);
      chk("perr_cmd_rdy", cmd_rdy, 1'b1);
      advance();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Reset in the middle of a write burst
    cmd_ena = 1'b1; cmd_write = 1'b1; cmd_id = 12'd9; cmd_len = 4'd3; aw_rdy = 1'b1;
    tick();
    cmd_ena = 1'b0;
    tick();
    wdata_ena = 1'b1; w_rdy = 1'b1; wdata_data = 32'h55;
    tick();
    wdata_ena = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; wdata_ena = 1'b1;
    settle();
    chk("mb_ar_ena", ar_ena, 1'b0);
    chk("mb_aw_ena", aw_ena, 1'b0);
    chk("mb_w_ena", w_ena, 1'b0);
    chk("mb_wdone", wdone_ena, 1'b0);
    chk("mb_cmd_rdy", cmd_rdy, 1'b1);
    advance();
    wdata_ena = 1'b0;

    // Randomized traffic against the model with a responding slave
    rbeat = 0;
    for (int c = 0; c < 3000; c++) begin
      cmd_ena    = ($urandom_range(2) == 0);
      cmd_write  = 1'($urandom_range(1));
      cmd_addr   = $urandom;
      cmd_id     = 12'($urandom);
      cmd_len    = 4'($urandom_range(3));
      ar_rdy     = 1'($urandom_range(1));
      aw_rdy     = 1'($urandom_range(1));
      w_rdy      = 1'($urandom_range(1));
      wdata_ena  = 1'($urandom_range(1));
      wdata_data = $urandom;
      rdata_rdy  = ($urandom_range(3) != 0);
      wdone_rdy  = ($urandom_range(3) != 0);
      r_data     = $urandom;
      r_resp     = 2'($urandom);
      if (rq_id.size() > 0) begin
        r_ena  = ($urandom_range(2) == 0);
        r_id   = 12'(rq_id[0]);
        r_last = (rbeat == rq_len[0]);
      end else begin
        r_ena  = 1'b0;
        r_last = 1'b0;
      end
      b_resp = 2'($urandom);
      if (bq.size() > 0) begin
        b_ena = 1'($urandom_range(1));
        b_id  = 12'(bq[0]);
      end else begin
        b_ena = 1'b0;
      end
      settle();
      advance();
      if (f_r) begin
        if (r_last) begin
          void'(rq_id.pop_front());
          void'(rq_len.pop_front());
          rbeat = 0;
        end else begin
          rbeat++;
        end
      end
      if (f_b) void'(bq.pop_front());
      if (f_ar) begin
        rq_id.push_back(int'(f_id));
        rq_len.push_back(int'(f_len));
      end
      if (f_w_last) bq.push_back(int'(f_id));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
